// File: rtl/megarom_pkg.sv
// Shared types and constants for the mega-ROM mapper with a memory handshake.
// Contents: mapper mode enum, FSM state enum, bank-register init values,
// and the is_16k() helper that tells ASCII16 apart from the 8 KB families.
package megarom_pkg;

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    ASCII8     = 2'd0,
    ASCII16    = 2'd1,
    KONAMI     = 2'd2,
    KONAMI_SCC = 2'd3
  } mapper_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_HOLD = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_HOLD = 3'd4
  } state_t;

  // Slot-reset bank values, two bits per bank, bank 3 in the top pair.
  localparam logic [7:0] INIT_8K  = 8'b11_10_01_00;
  localparam logic [7:0] INIT_16K = 8'b00_00_00_00;

  function automatic logic is_16k(input mapper_mode_t mode);
    return mode == ASCII16;
  endfunction

  function automatic logic [1:0] bank_init(input mapper_mode_t mode, input logic [1:0] idx);
    logic [7:0] tbl;
    tbl = is_16k(mode) ? INIT_16K : INIT_8K;
    return tbl[2*idx +: 2];
  endfunction

endpackage

// File: rtl/megarom_mapper_seq_if.sv
// Slot-bus and backing-memory signal bundle for megarom_mapper_seq.
// slave : the mapper's view (bus strobes/data in, DOUT/WAIT out, drives MEM_*).
// master: the environment's view (Z80 slot side plus memory arbiter side).
interface megarom_mapper_seq_if #(
  parameter int unsigned ADDR_W = 24
);
  logic [15:0]       BUS_ADDR;
  logic [7:0]        BUS_DIN;
  logic              BUS_SLTSL_n;
  logic              BUS_MERQ_n;
  logic              BUS_RD_n;
  logic              BUS_WR_n;
  logic [7:0]        BUS_DOUT;
  logic              BUS_BUSDIR_n;
  logic              BUS_WAIT_n;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic              MEM_ACK;
  logic [7:0]        MEM_RDATA;

  modport slave (
    input  BUS_ADDR, BUS_DIN, BUS_SLTSL_n, BUS_MERQ_n, BUS_RD_n, BUS_WR_n,
    output BUS_DOUT, BUS_BUSDIR_n, BUS_WAIT_n,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_ACK, MEM_RDATA
  );

  modport master (
    output BUS_ADDR, BUS_DIN, BUS_SLTSL_n, BUS_MERQ_n, BUS_RD_n, BUS_WR_n,
    input  BUS_DOUT, BUS_BUSDIR_n, BUS_WAIT_n,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_ACK, MEM_RDATA
  );
endinterface

// File: rtl/megarom_bank_decode.sv
// Combinational address decode for the four mapper families.
// Ports: addr/mode in; reg_hit_c/hit_idx_c flag a bank-register window,
// bank_idx_c/offset_c select the bank for a ROM access, in_rom_c marks 4000-BFFF.
module megarom_bank_decode
  import megarom_pkg::*;
(
  input  logic [15:0]  addr,
  input  mapper_mode_t mode,
  output logic         reg_hit_c,
  output logic [1:0]   hit_idx_c,
  output logic [1:0]   bank_idx_c,
  output logic [13:0]  offset_c,
  output logic         in_rom_c
);

  always_comb begin
    reg_hit_c  = 1'b0;
    hit_idx_c  = 2'd0;
    in_rom_c   = (addr[15:14] == 2'b01) || (addr[15:14] == 2'b10);
    bank_idx_c = {addr[15], addr[13]};
    offset_c   = {1'b0, addr[12:0]};
    if (is_16k(mode)) begin
      bank_idx_c = {1'b0, addr[15]};
      offset_c   = addr[13:0];
    end

    case (mode)
      ASCII8: begin
        // 6000/6800/7000/7800, 2 KB apart.
        if (addr[15:13] == 3'b011) begin
          reg_hit_c = 1'b1;
          hit_idx_c = addr[12:11];
        end
      end
      ASCII16: begin
        if (addr[15:11] == 5'b01100) begin
          reg_hit_c = 1'b1;
          hit_idx_c = 2'd0;
        end else if (addr[15:11] == 5'b01110) begin
          reg_hit_c = 1'b1;
          hit_idx_c = 2'd1;
        end
      end
      KONAMI: begin
        // 6000/8000/A000 map to banks 1/2/3, which is {A15,A13}; bank 0 is never hit.
        if (addr[15:13] == 3'b011 || addr[15:13] == 3'b100 || addr[15:13] == 3'b101) begin
          reg_hit_c = 1'b1;
          hit_idx_c = {addr[15], addr[13]};
        end
      end
      KONAMI_SCC: begin
        // 5000/7000/9000/B000: A12:11 = 10 inside the ROM window, index {A15,A13}.
        if (in_rom_c && addr[12:11] == 2'b10) begin
          reg_hit_c = 1'b1;
          hit_idx_c = {addr[15], addr[13]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/megarom_mapper_seq.sv
// MSX mega-ROM mapper with bank registers and a req/ack port to slow memory.
// Ports: CLK, RESET_n (async), BUS_RESET_n (slot reset, sync); pins carries
// the slot bus and memory handshake; CFG_* select mode, image base, bank mask
// and RAM-backed writes; BANK_REGS exposes banks 3..0; TIMEOUT_ERR pulses on abort.
module megarom_mapper_seq
  import megarom_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned BANK_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  BUS_RESET_n,
  megarom_mapper_seq_if.slave   pins,
  input  logic [1:0]            CFG_MODE,
  input  logic [ADDR_W-1:0]     CFG_TOP_ADDR,
  input  logic [BANK_W-1:0]     CFG_BANK_MASK,
  input  logic                  CFG_WRITE_EN,
  output logic [4*BANK_W-1:0]   BANK_REGS,
  output logic                  TIMEOUT_ERR
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mapper_mode_t      mode_c;
  logic              reg_hit_c, in_rom_c;
  logic [1:0]        hit_idx_c, bank_idx_c;
  logic [13:0]       offset_c;
  logic [BANK_W-1:0] bank_q [NUM_BANKS];
  logic [BANK_W-1:0] bank_sel_c;
  logic [ADDR_W-1:0] rom_off_c, mem_addr_c;
  logic              rd_c, wr_c, rd_edge_c, wr_edge_c;

  state_t            state_q, state_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d, dout_q, dout_d;
  logic              busdir_q, busdir_d, wait_q, wait_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign mode_c = mapper_mode_t'(CFG_MODE);

  megarom_bank_decode u_decode (
    .addr       (pins.BUS_ADDR),
    .mode       (mode_c),
    .reg_hit_c  (reg_hit_c),
    .hit_idx_c  (hit_idx_c),
    .bank_idx_c (bank_idx_c),
    .offset_c   (offset_c),
    .in_rom_c   (in_rom_c)
  );

  // Strobe qualification and rising-edge detection.
  assign rd_c      = !pins.BUS_SLTSL_n && !pins.BUS_MERQ_n && !pins.BUS_RD_n && in_rom_c;
  assign wr_c      = !pins.BUS_SLTSL_n && !pins.BUS_MERQ_n && !pins.BUS_WR_n;
  assign rd_edge_c = rd_c && !rd_q;
  assign wr_edge_c = wr_c && !wr_q;

  // Backing-memory address: image base plus {bank, offset}, truncated to ADDR_W.
  assign bank_sel_c = bank_q[bank_idx_c];
  assign rom_off_c  = is_16k(mode_c) ? ADDR_W'({bank_sel_c, offset_c})
                                     : ADDR_W'({bank_sel_c, offset_c[12:0]});
  assign mem_addr_c = ADDR_W'(CFG_TOP_ADDR + rom_off_c);

  // Bank registers: register writes are taken in any FSM state.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= '0;
    end else if (!BUS_RESET_n) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= BANK_W'(bank_init(mode_c, 2'(i)));
    end else if (wr_edge_c && reg_hit_c) begin
      bank_q[hit_idx_c] <= BANK_W'(pins.BUS_DIN) & CFG_BANK_MASK;
    end
  end

  // FSM and registered outputs: state register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= ST_IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      busdir_q <= 1'b1;
      wait_q   <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      busdir_q <= busdir_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // FSM next state and next output values.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_c;
    wr_d     = wr_c;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    busdir_d = busdir_q;
    wait_d   = wait_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    if (!BUS_RESET_n) begin
      // Abandon any pending request; memory side copes with the dropped REQ.
      state_d  = ST_IDLE;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      req_d    = 1'b0;
      wait_d   = 1'b1;
      busdir_d = 1'b1;
      dout_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_edge_c) begin
            addr_d  = mem_addr_c;
            req_d   = 1'b1;
            we_d    = 1'b0;
            wait_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_RD_REQ;
          end else if (wr_edge_c && CFG_WRITE_EN && in_rom_c && !reg_hit_c) begin
            addr_d  = mem_addr_c;
            wdata_d = pins.BUS_DIN;
            req_d   = 1'b1;
            we_d    = 1'b1;
            wait_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_WR_REQ;
          end
        end
        ST_RD_REQ: begin
          if (pins.MEM_ACK) begin
            dout_d   = pins.MEM_RDATA;
            busdir_d = 1'b0;
            req_d    = 1'b0;
            wait_d   = 1'b1;
            state_d  = ST_RD_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            // No ACK in time: float FF onto the bus and release the Z80.
            dout_d   = 8'hFF;
            busdir_d = 1'b0;
            req_d    = 1'b0;
            wait_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = ST_RD_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RD_HOLD: begin
          if (!rd_c) begin
            dout_d   = '0;
            busdir_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          if (pins.MEM_ACK) begin
            req_d   = 1'b0;
            wait_d  = 1'b1;
            state_d = ST_WR_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            req_d   = 1'b0;
            wait_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_WR_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          if (!wr_c) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pins.MEM_REQ      = req_q;
  assign pins.MEM_WE       = we_q;
  assign pins.MEM_ADDR     = addr_q;
  assign pins.MEM_WDATA    = wdata_q;
  assign pins.BUS_DOUT     = dout_q;
  assign pins.BUS_BUSDIR_n = busdir_q;
  assign pins.BUS_WAIT_n   = wait_q;
  assign TIMEOUT_ERR       = err_q;
  assign BANK_REGS         = {bank_q[3], bank_q[2], bank_q[1], bank_q[0]};

endmodule
